// File: rtl/gcd_pkg.sv
// Shared types for the GCD engine: FSM state encodings and a worst-case step helper.
// The optional step counter in gcd_engine is enabled by defining GCD_STEP_COUNT_EN.
package gcd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        DONE = ST_DONE
    } state_t;

    // Operands (2^width-1, 1) need 2^width-2 subtractions; used to bound waits.
    function automatic int unsigned worst_steps(input int unsigned width);
        return (32'd1 << width) - 32'd2;
    endfunction

endpackage

// File: rtl/gcd_sub_core.sv
// Combinational compare/subtract stage of the GCD engine: flags plus larger-minus-smaller.
module gcd_sub_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             eq,
    output logic             x_zero,
    output logic             y_zero,
    output logic             x_gt_y,
    output logic [WIDTH-1:0] diff
);

    assign eq     = (x == y);
    assign x_zero = (x == '0);
    assign y_zero = (y == '0);
    assign x_gt_y = (x > y);
    // The larger operand is always the minuend, so this never wraps.
    assign diff   = x_gt_y ? (x - y) : (y - x);

endmodule

// File: rtl/gcd_engine.sv
// Subtractive GCD engine with valid/ready on operands and result, one operation in flight.
// Define GCD_STEP_COUNT_EN to add the saturating subtraction step counter on out_steps.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic             busy
`ifdef GCD_STEP_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_steps
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready and out_valid are pure state decodes, so neither depends on the
    // opposite-side input in the same cycle.

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] result;

    logic             eq;
    logic             x_zero;
    logic             y_zero;
    logic             x_gt_y;
    logic [WIDTH-1:0] diff;
    logic             finish;

    gcd_sub_core #(.WIDTH(WIDTH)) u_sub_core (
        .x      (x),
        .y      (y),
        .eq     (eq),
        .x_zero (x_zero),
        .y_zero (y_zero),
        .x_gt_y (x_gt_y),
        .diff   (diff)
    );

    // Any of these ends the computation; GCD(0,0) exits through eq.
    assign finish = eq || x_zero || y_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (finish)    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x      <= '0;
            y      <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x <= in_a;
                        y <= in_b;
                    end
                end
                CALC: begin
                    if (eq)          result <= x;
                    else if (x_zero) result <= y;
                    else if (y_zero) result <= x;
                    else if (x_gt_y) x      <= diff;
                    else             y      <= diff;
                end
                default: ;
            endcase
        end
    end

`ifdef GCD_STEP_COUNT_EN
    localparam logic [CNT_W-1:0] STEPS_MAX = '1;
    logic [CNT_W-1:0] steps;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            steps <= '0;
        end else if (state == IDLE && in_valid) begin
            steps <= '0;
        end else if (state == CALC && !finish && steps != STEPS_MAX) begin
            steps <= steps + CNT_W'(1);
        end
    end

    assign out_steps = steps;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state == CALC);
    assign out_valid = (state == DONE);
    assign out_gcd   = result;

endmodule
